// File: rtl/dec_entry_to_bin_pkg.sv
// Shared definitions for the decimal-entry accumulator and its helpers.
// Used by dec_entry_to_bin and mul10_add.
package dec_entry_to_bin_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } dec_state_e;

  localparam int unsigned      DEC_DIG_W       = 4;
  localparam logic [DEC_DIG_W-1:0] DEC_MAX_DIGIT = 4'd9;
  localparam int unsigned      DEC_MAXVAL_DFLT = 99;

  function automatic logic dec_digit_ok(input logic [DEC_DIG_W-1:0] d);
    return d <= DEC_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/dec_entry_to_bin_mul10_add.sv
// Combinational cur*10 + dig, built from shifts, at full BW+4 width so the
// caller can range-check before truncating.
module mul10_add
  import dec_entry_to_bin_pkg::*;
#(
  parameter int unsigned BW = 7
) (
  input  logic [BW-1:0]        cur,
  input  logic [DEC_DIG_W-1:0] dig,
  output logic [BW+3:0]        res
);

  logic [BW+3:0] cur_w;
  logic [BW+3:0] dig_w;

  always_comb begin
    cur_w = (BW+4)'(cur);
    dig_w = (BW+4)'(dig);
    res   = (cur_w << 3) + (cur_w << 1) + dig_w;
  end

endmodule

// File: rtl/dec_entry_to_bin.sv
// Sequential BCD digit entry (MSD first) to binary, with valid/ready commit.
// Build option: define DEC_ENTRY_SAT_EN to saturate at MAXVAL instead of rejecting.
module dec_entry_to_bin
  import dec_entry_to_bin_pkg::*;
#(
  parameter int unsigned NDIG   = 2,
  parameter int unsigned BW     = 7,
  parameter int unsigned MAXVAL = DEC_MAXVAL_DFLT
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 DIG_VALID,
  input  logic [DEC_DIG_W-1:0] DIG,
  input  logic                 CLR,
  input  logic                 ENTER,
  output logic [BW-1:0]        CUR,
  output logic [1:0]           NCNT,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [BW-1:0]        BIN,
  output logic                 ERR
);

  localparam logic [1:0]    NDIG_C = 2'(NDIG);
  localparam logic [BW+3:0] MAXV_W = (BW+4)'(MAXVAL);
  localparam logic [BW-1:0] MAXV_B = BW'(MAXVAL);

  dec_state_e    state, state_nx;
  logic [BW-1:0] cur_nx, bin_nx;
  logic [1:0]    ncnt_nx;
  logic          ov_nx, err_nx;
  logic [BW+3:0] prod;
  logic          digit_ok;

  mul10_add #(.BW(BW)) u_mul10_add (
    .cur (CUR),
    .dig (DIG),
    .res (prod)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= EMPTY;
      CUR       <= '0;
      NCNT      <= '0;
      BIN       <= '0;
      OUT_VALID <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      state     <= state_nx;
      CUR       <= cur_nx;
      NCNT      <= ncnt_nx;
      BIN       <= bin_nx;
      OUT_VALID <= ov_nx;
      ERR       <= err_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cur_nx   = CUR;
    ncnt_nx  = NCNT;
    bin_nx   = BIN;
    ov_nx    = OUT_VALID;
    err_nx   = 1'b0;
    digit_ok = dec_digit_ok(DIG);

    case (state)
      EMPTY: begin
        if (CLR) begin
          cur_nx  = '0;
          ncnt_nx = '0;
        end else if (ENTER) begin
          err_nx = 1'b1;
        end else if (DIG_VALID) begin
          if (digit_ok) begin
            cur_nx   = BW'(DIG);
            ncnt_nx  = 2'd1;
            state_nx = ENTRY;
          end else begin
            err_nx = 1'b1;
          end
        end
      end

      ENTRY: begin
        if (CLR) begin
          cur_nx   = '0;
          ncnt_nx  = '0;
          state_nx = EMPTY;
        end else if (ENTER) begin
          // a digit arriving with ENTER is dropped silently
          bin_nx   = CUR;
          ov_nx    = 1'b1;
          state_nx = HOLD;
        end else if (DIG_VALID) begin
          if (!digit_ok || NCNT >= NDIG_C) begin
            err_nx = 1'b1;
          end else if (prod > MAXV_W) begin
`ifdef DEC_ENTRY_SAT_EN
            cur_nx  = MAXV_B;
            ncnt_nx = NCNT + 2'd1;
`else
            err_nx = 1'b1;
`endif
          end else begin
            cur_nx  = prod[BW-1:0];
            ncnt_nx = NCNT + 2'd1;
          end
        end
      end

      HOLD: begin
        if (OUT_VALID && OUT_READY) begin
          ov_nx    = 1'b0;
          cur_nx   = '0;
          ncnt_nx  = '0;
          state_nx = EMPTY;
        end
      end

      default: begin
        state_nx = EMPTY;
      end
    endcase
  end

endmodule

// File: doc/dec_entry_to_bin.md
Name: dec_entry_to_bin

Overview:
- Sequential decimal-entry accumulator: takes BCD digits one at a time, most significant first, and builds the binary value.
- Inverse direction of the team's binary-to-decimal display converter.
- Sits between the game's keypad/button debounce logic and the score/guess comparison logic.
- Delivers the committed binary value through a valid/ready handshake; also exposes the live partial value for on-screen echo.

Parameters:
- NDIG, 2, maximum number of digits accepted per entry.
- BW, 7, width of the binary result.
- MAXVAL, 99, largest legal committed value; must be less than 2**BW.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  asynchronous, active-low reset.
- DIG_VALID  input  1  one-cycle strobe; DIG is valid.
- DIG  input  4  BCD digit, 0-9; values 10-15 are illegal.
- CLR  input  1  discard the current entry.
- ENTER  input  1  request commit of the current entry.
- CUR  output  BW  live partial value.
- NCNT  output  2  number of digits accepted so far (width covers NDIG).
- OUT_VALID  output  1  committed value available.
- OUT_READY  input  1  consumer accepts the committed value.
- BIN  output  BW  committed binary value, stable while OUT_VALID is high.
- ERR  output  1  one-cycle pulse on a rejected digit or rejected ENTER.

Behaviour:
- Reset (RST low, asynchronous): state EMPTY, CUR=0, NCNT=0, BIN=0, OUT_VALID=0, ERR=0.
- States: EMPTY, ENTRY, HOLD.

EMPTY:
- DIG_VALID with DIG<=9: CUR<=DIG, NCNT<=1, go to ENTRY.
- ENTER in EMPTY: ERR pulse, no state change.

ENTRY:
- DIG_VALID with a legal digit and NCNT<NDIG: CUR<=CUR*10+DIG, NCNT<=NCNT+1.
- Result above MAXVAL: handled per Optional Feature.
- NCNT==NDIG: further digits are rejected with an ERR pulse; CUR is unchanged.
- ENTER: BIN<=CUR, OUT_VALID<=1, go to HOLD. OUT_VALID rises the cycle after ENTER (1-cycle latency).

HOLD:
- Digits are ignored and raise no ERR.
- OUT_VALID && OUT_READY: next cycle OUT_VALID=0, CUR=0, NCNT=0, state EMPTY.
- BIN holds its last value after the handshake.

Illegal digit (DIG>=10) in any state except HOLD: ERR pulse; state and CUR unchanged.

CLR:
- In EMPTY or ENTRY: CUR=0, NCNT=0, state EMPTY next cycle.
- In HOLD: CLR is ignored; the handshake must complete first.

Priority within one cycle: CLR > ENTER > DIG_VALID.
- ENTER and DIG_VALID together: the commit uses CUR before the digit; the digit is dropped without ERR.

Arithmetic:
- CUR*10 computed as (CUR<<3)+(CUR<<1) in BW+4 bits, then DIG added.
- The overflow compare uses the full width; the result is truncated to BW only after the compare.

ERR is registered and high for exactly one cycle per rejected event.

Optional Feature:
- Macro DEC_ENTRY_SAT_EN.
- Defined: a digit that would make CUR exceed MAXVAL is accepted with CUR<=MAXVAL, NCNT incremented, and no ERR.
- Undefined: that digit is rejected, CUR and NCNT are unchanged, and ERR pulses.

Decomposition:
- Shared game package holds:
  - state encoding constants (EMPTY=2'd0, ENTRY=2'd1, HOLD=2'd2);
  - the BCD digit width (4);
  - DEC_MAX_DIGIT (9);
  - default MAXVAL (99).
- One natural sub-module: mul10_add, purely combinational, inputs CUR and DIG, output BW+4-bit CUR*10+DIG. It is reused by future multi-digit entry widgets.
- The FSM, counters and handshake live in the top module.

Test Plan:
- Reset mid-entry: digits 4,2 entered, RST low asynchronously -> CUR=0, NCNT=0, OUT_VALID=0 immediately, before the next CLK edge.
- Digits 4 then 2, ENTER, OUT_READY held low 5 cycles then high -> OUT_VALID rises 1 cycle after ENTER; BIN=42 held all 5 cycles; OUT_VALID drops 1 cycle after OUT_READY; state EMPTY, CUR=0.
- Digits 9,9,7 (NDIG=2) -> CUR=99 after two digits; third digit gives an ERR pulse; ENTER commits BIN=99.
- MAXVAL=50, digits 5 then 7 -> with DEC_ENTRY_SAT_EN, CUR=50 and no ERR; without it, CUR=5 and one ERR pulse.
- Digit 12, then digit 3, then CLR, then ENTER -> ERR on 12 with CUR=0; CUR=3 after the 3; CLR gives CUR=0 in EMPTY; ENTER in EMPTY gives ERR and no OUT_VALID.
- Digit 6, then ENTER and DIG_VALID(DIG=1) in the same cycle -> BIN=6, no ERR; digits during HOLD leave BIN=6 and CUR=6.
